// File: rtl/issue_arbiter.sv
// Per-cycle issue scheduler: one round-robin grant per functional-unit class,
// gated by free pipelines minus last cycle's in-flight reservations.
module issue_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [3:0]         req_fu_type_i [NUM_REQ],
  input  logic [1:0]         fu_int_free_i,
  input  logic               fu_mul_free_i,
  input  logic [1:0]         fu_vec_free_i,
  input  logic [1:0]         fu_mem_free_i,
  input  logic               fu_branch_free_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [NUM_REQ-1:0] issue_valid_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  localparam int         NUM_CLS = 5;
  localparam int         PTR_W   = 3;
  localparam logic [2:0] CLS_BR  = 3'd4;

  logic [2:0]         slot_cls  [NUM_REQ];
  logic [1:0]         free_cnt  [NUM_CLS];
  logic [PTR_W-1:0]   rr_q      [NUM_CLS];
  logic [PTR_W-1:0]   gnt_idx   [NUM_CLS];
  logic [PTR_W-1:0]   scan_idx;
  logic [NUM_CLS-1:0] pend_q;
  logic [NUM_CLS-1:0] cls_avail;
  logic [NUM_CLS-1:0] cls_grant;
  logic [NUM_REQ-1:0] grant_raw;

  // Every fu_type of 4 and above is a branch.
  always_comb begin
    for (int j = 0; j < NUM_REQ; j++) begin
      slot_cls[j] = (req_fu_type_i[j] >= 4'd4) ? CLS_BR : req_fu_type_i[j][2:0];
    end
  end

  always_comb begin
    free_cnt[0] = 2'(fu_int_free_i[0]) + 2'(fu_int_free_i[1]);
    free_cnt[1] = {1'b0, fu_mul_free_i};
    free_cnt[2] = 2'(fu_vec_free_i[0]) + 2'(fu_vec_free_i[1]);
    free_cnt[3] = 2'(fu_mem_free_i[0]) + 2'(fu_mem_free_i[1]);
    free_cnt[4] = {1'b0, fu_branch_free_i};
    // A pipeline granted last cycle still shows as free; it is held back here.
    for (int c = 0; c < NUM_CLS; c++) begin
      cls_avail[c] = free_cnt[c] > {1'b0, pend_q[c]};
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    grant_raw = '0;
    cls_grant = '0;
    scan_idx  = '0;
    for (int c = 0; c < NUM_CLS; c++) begin
      gnt_idx[c] = '0;
    end
    for (int c = 0; c < NUM_CLS; c++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = rr_q[c] + PTR_W'(k);
        if (cls_avail[c] && !cls_grant[c] && req_valid_i[scan_idx] &&
            slot_cls[scan_idx] == 3'(c)) begin
          cls_grant[c]        = 1'b1;
          gnt_idx[c]          = scan_idx;
          grant_raw[scan_idx] = 1'b1;
        end
      end
    end
  end

  assign grant_o = (flush_i || rst) ? '0 : grant_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid_o <= '0;
      pend_q        <= '0;
      stall_cnt_o   <= '0;
      for (int c = 0; c < NUM_CLS; c++) begin
        rr_q[c] <= '0;
      end
    end else if (flush_i) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      issue_valid_o <= '0;
      pend_q        <= '0;
    end else begin
      issue_valid_o <= grant_o;
      pend_q        <= cls_grant;
      for (int c = 0; c < NUM_CLS; c++) begin
        if (cls_grant[c]) begin
          rr_q[c] <= gnt_idx[c] + PTR_W'(1);
        end
      end
      if (|req_valid_i && grant_o == '0 && stall_cnt_o != '1) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_issue_arbiter.sv
// Scoreboarded random/directed bench for issue_arbiter against a behavioural
// model of the class-scheduling rules.
module tb_issue_arbiter;

  typedef struct {
    logic [7:0]  grant;
    logic [7:0]  ivalid;
    logic [31:0] stall;
    logic [3:0]  stall4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [7:0]  valid;
  logic [3:0]  fu_type [8];
  logic [7:0]  free;   // [1:0] int, [2] mul, [4:3] vec, [6:5] mem, [7] branch
  logic [7:0]  grant, ivalid, grant4, ivalid4;
  logic [31:0] stall;
  logic [3:0]  stall4;

  logic        n_rst, n_flush;
  logic [7:0]  n_valid, n_free;
  logic [3:0]  n_type [8];

  int unsigned m_rr [5];
  bit          m_pend [5];
  bit          m_cg [5];
  int          m_gi [5];
  logic [7:0]  m_grant, m_ivalid;
  int unsigned m_stall, m_stall4;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  issue_arbiter #(.NUM_REQ(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .req_valid_i(valid),
    .req_fu_type_i(fu_type), .fu_int_free_i(free[1:0]), .fu_mul_free_i(free[2]),
    .fu_vec_free_i(free[4:3]), .fu_mem_free_i(free[6:5]), .fu_branch_free_i(free[7]),
    .grant_o(grant), .issue_valid_o(ivalid), .stall_cnt_o(stall)
  );

  issue_arbiter #(.NUM_REQ(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush_i(flush), .req_valid_i(valid),
    .req_fu_type_i(fu_type), .fu_int_free_i(free[1:0]), .fu_mul_free_i(free[2]),
    .fu_vec_free_i(free[4:3]), .fu_mem_free_i(free[6:5]), .fu_branch_free_i(free[7]),
    .grant_o(grant4), .issue_valid_o(ivalid4), .stall_cnt_o(stall4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cls_of(input logic [3:0] t);
    return (t >= 4'd4) ? 4 : int'(t);
  endfunction

  function automatic int free_of(input int c, input logic [7:0] f);
    case (c)
      0:       return $countones(f[1:0]);
      1:       return int'(f[2]);
      2:       return $countones(f[4:3]);
      3:       return $countones(f[6:5]);
      default: return int'(f[7]);
    endcase
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < 5; c++) begin
      m_rr[c]   = 0;
      m_pend[c] = 1'b0;
    end
    m_ivalid = '0;
    m_stall  = 0;
    m_stall4 = 0;
  endfunction

  // Expected outputs for the cycle whose inputs were just applied.
  function automatic void model_eval();
    int best, bestd, d;
    if (rst) model_clear();
    m_grant = '0;
    for (int c = 0; c < 5; c++) m_cg[c] = 1'b0;
    if (!rst && !flush) begin
      for (int c = 0; c < 5; c++) begin
        best  = -1;
        bestd = 8;
        for (int j = 0; j < 8; j++) begin
          if (valid[j] && cls_of(fu_type[j]) == c) begin
            d = (j - int'(m_rr[c]) + 8) % 8;
            if (d < bestd) begin
              bestd = d;
              best  = j;
            end
          end
        end
        if (best >= 0 && free_of(c, free) > int'(m_pend[c])) begin
          m_cg[c]       = 1'b1;
          m_gi[c]       = best;
          m_grant[best] = 1'b1;
        end
      end
    end
    sb.push_back('{m_grant, m_ivalid, m_stall, 4'(m_stall4)});
  endfunction

  // State change at the rising edge, from the inputs of the ending cycle.
  function automatic void model_edge();
    if (rst) begin
      model_clear();
    end else if (flush) begin
      m_ivalid = '0;
      for (int c = 0; c < 5; c++) m_pend[c] = 1'b0;
    end else begin
      m_ivalid = m_grant;
      for (int c = 0; c < 5; c++) begin
        m_pend[c] = m_cg[c];
        if (m_cg[c]) m_rr[c] = (m_gi[c] + 1) % 8;
      end
      if (valid != 0 && m_grant == 0) begin
        m_stall++;
        if (m_stall4 < 15) m_stall4++;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    rst   = n_rst;
    flush = n_flush;
    valid = n_valid;
    free  = n_free;
    for (int j = 0; j < 8; j++) fu_type[j] = n_type[j];
    model_eval();
  endtask

  task automatic idle(input int n);
    n_valid = '0;
    n_flush = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("grant", 64'(grant), 64'(e.grant));
      check("issue_valid", 64'(ivalid), 64'(e.ivalid));
      check("stall_cnt", 64'(stall), 64'(e.stall));
      check("stall_cnt_w4", 64'(stall4), 64'(e.stall4));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b1; n_flush = 1'b0; n_valid = 8'hFF; n_free = 8'hFF;
    for (int j = 0; j < 8; j++) n_type[j] = 4'd0;
    rst = 1'b1; flush = 1'b0; valid = 8'hFF; free = 8'hFF;
    for (int j = 0; j < 8; j++) fu_type[j] = 4'd0;
    model_clear();
    m_grant = '0;
    for (int c = 0; c < 5; c++) m_cg[c] = 1'b0;

    // Reset held with everything requesting, then released.
    for (int i = 0; i < 3; i++) step();
    n_rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    idle(2);

    // One grant per class in parallel, then mul held back by its reservation.
    for (int j = 0; j < 5; j++) n_type[j] = 4'(j);
    n_valid = 8'h1F;
    for (int i = 0; i < 3; i++) step();
    idle(2);

    // Round-robin among int slots 2, 5, 7.
    for (int j = 0; j < 8; j++) n_type[j] = 4'd0;
    n_valid = 8'b1010_0100;
    for (int i = 0; i < 7; i++) step();
    idle(2);

    // Single branch pipeline alternates.
    n_type[3] = 4'd9;
    n_valid   = 8'b0000_1000;
    for (int i = 0; i < 6; i++) step();
    idle(2);

    // Flush one cycle after a grant, requests kept up throughout.
    n_type[3] = 4'd0;
    n_valid   = 8'h09;
    step();
    n_flush = 1'b1;
    step();
    n_flush = 1'b0;
    for (int i = 0; i < 3; i++) step();
    idle(2);

    // Mem starvation drives both counters, the 4-bit one into saturation.
    for (int j = 0; j < 8; j++) n_type[j] = 4'd3;
    n_valid = 8'hFF;
    n_free  = 8'b1001_1111;
    for (int i = 0; i < 30; i++) step();
    n_free = 8'hFF;
    idle(2);

    // Random traffic with occasional flush and asynchronous reset pulses.
    for (int i = 0; i < 400; i++) begin
      n_valid = 8'($urandom);
      n_free  = 8'($urandom);
      for (int j = 0; j < 8; j++) begin
        n_type[j] = ($urandom_range(0, 5) == 5) ? 4'($urandom_range(4, 15))
                                                : 4'($urandom_range(0, 4));
      end
      n_flush = ($urandom_range(0, 15) == 0);
      n_rst   = ($urandom_range(0, 63) == 0);
      step();
    end
    n_rst = 1'b0;
    idle(2);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
